// File: rtl/npem_pkg.sv
// Shared definitions for the NPEM control/status block: register bit
// positions, status bit positions and the command FSM state type.
package npem_pkg;

  // NPEM Control / Capability bit positions
  localparam int unsigned NPEM_EN    = 0;
  localparam int unsigned NPEM_RESET = 1;
  localparam int unsigned OK         = 2;
  localparam int unsigned LOCATE     = 3;
  localparam int unsigned FAIL       = 4;
  localparam int unsigned REBUILD    = 5;
  localparam int unsigned PFA        = 6;
  localparam int unsigned HOT_SPARE  = 7;
  localparam int unsigned ICA        = 8;
  localparam int unsigned IFA        = 9;
  localparam int unsigned INVALID    = 10;
  localparam int unsigned DISABLED   = 11;
  localparam int unsigned ENCL_LSB   = 24;

  // NPEM Status bit positions
  localparam int unsigned CC = 0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } npem_state_e;

endpackage

// File: rtl/npem_cmd_timer.sv
// Loadable up-counter with synchronous clear and an expiry flag that is
// high while the count equals LIMIT-1. Used to bound enclosure handshakes.
module npem_cmd_timer #(
  parameter int unsigned LIMIT     = 1000000,
  parameter int unsigned CNT_WIDTH = $clog2(LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 en,
  output logic                 expired
);

  logic [CNT_WIDTH-1:0] count_q;

  // Counter register: clear beats load beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry flag on the last allowed count
  always_comb begin
    expired = (count_q == CNT_WIDTH'(LIMIT - 1));
  end

endmodule

// File: rtl/npem_control_status.sv
// NPEM Control and Status registers. Accepted control writes are masked by
// the capability word and forwarded to the enclosure over a req/ack
// handshake bounded by a timeout; completion sets Command Completed.
module npem_control_status
  import npem_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REGISTER_WIDTH-1:0] cap_in,
  input  logic                      ctl_wr_en,
  input  logic [REGISTER_WIDTH-1:0] ctl_wr_data,
  output logic [REGISTER_WIDTH-1:0] ctl_rd_data,
  input  logic                      sts_wr_en,
  input  logic [REGISTER_WIDTH-1:0] sts_wr_data,
  output logic [REGISTER_WIDTH-1:0] sts_rd_data,
  input  logic                      cc_int_en,
  output logic                      encl_req,
  output logic [REGISTER_WIDTH-1:0] encl_cmd,
  input  logic                      encl_ack,
  input  logic [7:0]                encl_sts,
  output logic                      npem_irq,
  output logic                      timeout_err
);

  npem_state_e               state_q, state_d;
  logic [REGISTER_WIDTH-1:0] ctl_q, ctl_d;
  logic [REGISTER_WIDTH-1:0] cmd_q;
  logic [REGISTER_WIDTH-1:0] wr_mask, masked, issue_cmd;
  logic                      pend_q, pend_rst_q;
  logic                      cc_q, irq_q, terr_q;
  logic [7:0]                encl_q;
  logic                      accepted, rst_bit, expired, finish, reissue;

  // Write qualification, masking and completion/reissue decisions
  always_comb begin
    wr_mask = '0;
    wr_mask[NPEM_EN] = 1'b1;
    wr_mask[DISABLED:OK] = '1;
    wr_mask[REGISTER_WIDTH-1:ENCL_LSB] = '1;
    accepted = ctl_wr_en & cap_in[NPEM_EN];
    masked   = ctl_wr_data & cap_in & wr_mask;
    rst_bit  = ctl_wr_data[NPEM_RESET] & cap_in[NPEM_RESET];
    finish   = (state_q == ISSUE) & (encl_ack | expired);
    reissue  = (state_q == DONE) & (pend_q | accepted);
  end

  // Next control value: completed Initiate Reset clears indications, a write overrides
  always_comb begin
    ctl_d = ctl_q;
    if ((state_q == DONE) && cmd_q[NPEM_RESET]) begin
      ctl_d = '0;
      ctl_d[NPEM_EN] = ctl_q[NPEM_EN];
    end
    if (accepted) begin
      ctl_d = masked;
    end
  end

  // Command word to launch: fresh write from IDLE, or the collapsed pending write from DONE
  always_comb begin
    if (state_q == DONE) begin
      issue_cmd = ctl_d;
      issue_cmd[NPEM_RESET] = pend_rst_q | (accepted & rst_bit);
    end else begin
      issue_cmd = masked;
      issue_cmd[NPEM_RESET] = rst_bit;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accepted) state_d = ISSUE;
      ISSUE:   if (finish)   state_d = DONE;
      DONE:    state_d = reissue ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control register, command word and pending-write tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q      <= '0;
      cmd_q      <= '0;
      pend_q     <= 1'b0;
      pend_rst_q <= 1'b0;
    end else begin
      ctl_q <= ctl_d;
      if ((state_q == IDLE) && accepted) begin
        cmd_q <= issue_cmd;
      end else if ((state_q == ISSUE) && accepted) begin
        pend_q     <= 1'b1;
        pend_rst_q <= pend_rst_q | rst_bit;
      end else if (reissue) begin
        cmd_q      <= issue_cmd;
        pend_q     <= 1'b0;
        pend_rst_q <= 1'b0;
      end
    end
  end

  // Status register and completion pulses; CC is set entering and during DONE so set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q   <= 1'b0;
      encl_q <= '0;
      irq_q  <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      encl_q <= encl_sts;
      irq_q  <= finish & cc_int_en & ~cc_q;
      terr_q <= (state_q == ISSUE) & expired & ~encl_ack;
      if (finish || (state_q == DONE)) begin
        cc_q <= 1'b1;
      end else if (sts_wr_en && sts_wr_data[CC]) begin
        cc_q <= 1'b0;
      end
    end
  end

  npem_cmd_timer #(
    .LIMIT     (TIMEOUT_CYCLES),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == DONE),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_q == ISSUE),
    .expired  (expired)
  );

  // Output assembly
  always_comb begin
    sts_rd_data = '0;
    sts_rd_data[CC] = cc_q;
    sts_rd_data[ENCL_LSB +: 8] = encl_q;
    ctl_rd_data = ctl_q;
    encl_req    = (state_q == ISSUE);
    encl_cmd    = cmd_q;
    npem_irq    = irq_q;
    timeout_err = terr_q;
  end

endmodule
